// File: rtl/seq_tx_pkg.sv
// seq_tx_pkg: shared types and helpers for the serial test-pattern transmitter.
//   state_t    - transmitter FSM states
//   SEG_*      - active-low 7-segment codes, bit order {a,b,c,d,e,f,g}
//   seg_decode - digit 0..9 to segment code (blank for anything else)
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/tick_div.sv
// tick_div: free-running divider, counts 0..TICK_DIV-1 and wraps.
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the counter
//   tick - one-cycle pulse while the counter sits at TICK_DIV-1
module tick_div #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_tx_gen.sv
// seq_tx_gen: serial test-pattern transmitter feeding a sequence detector.
// Shifts a loadable pattern out MSB-first, one bit per slow tick.
//   clk, rst          - clock, synchronous active-high reset
//   pat_in, len_in    - pattern / length offered (len 0 or >PAT_W means PAT_W)
//   load_valid/ready  - load handshake, only accepted in IDLE
//   start             - level-sampled start request
//   x_out, bit_stb    - serial data and new-bit strobe
//   busy, done        - transmission active / end-of-sequence pulse
//   a..g              - active-low segments showing the bits-emitted count
//   blinkled          - toggles on every tick
// Optional: define SEQ_TX_LOOP_EN to repeat the pattern while start stays high.
module seq_tx_gen
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               TICK_DIV    = 20000000,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(8'b0011_0000),
    parameter logic [3:0]       DEFAULT_LEN = 4'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [3:0]       len_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             start,
    output logic             x_out,
    output logic             bit_stb,
    output logic             busy,
    output logic             done,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             g,
    output logic             blinkled
);

    state_t state, state_n;

    logic             tick;
    logic [PAT_W-1:0] pat_q;
    logic [3:0]       len_q;
    logic [3:0]       idx;
    logic [3:0]       count;
    logic [6:0]       seg_q;
    logic [3:0]       eff_len;
    logic [PAT_W-1:0] pat_sh;
    logic             load_fire;
    logic             go_bit;
    logic             wrap;

    tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign load_ready = (state == IDLE);
    assign load_fire  = load_valid && load_ready;
    assign busy       = (state != IDLE);
    assign eff_len    = ((len_in == 4'd0) || (len_in > 4'(PAT_W))) ? 4'(PAT_W) : len_in;
    // Current bit lands in the MSB after shifting by the bit index.
    assign pat_sh     = pat_q << idx;

    assign {a, b, c, d, e, f, g} = seg_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        go_bit  = 1'b0;
        wrap    = 1'b0;
        case (state)
            IDLE: if (start) state_n = RUN;
            RUN: begin
                if (tick) begin
                    if (idx < len_q) begin
                        go_bit = 1'b1;
                    end else begin
`ifdef SEQ_TX_LOOP_EN
                        // Loop back to bit 0 while start is still held.
                        if (start) wrap = 1'b1;
                        else       state_n = DONE;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q    <= DEFAULT_PAT;
            len_q    <= DEFAULT_LEN;
            idx      <= '0;
            count    <= '0;
            x_out    <= 1'b0;
            bit_stb  <= 1'b0;
            done     <= 1'b0;
            blinkled <= 1'b0;
            seg_q    <= SEG_0;
        end else begin
            bit_stb <= 1'b0;
            done    <= 1'b0;
            if (tick) blinkled <= ~blinkled;
            // A load coinciding with start is what gets transmitted.
            if (load_fire) begin
                pat_q <= pat_in;
                len_q <= eff_len;
            end
            case (state)
                IDLE: begin
                    x_out <= 1'b0;
                    if (start) begin
                        idx   <= '0;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (go_bit) begin
                        x_out   <= pat_sh[PAT_W-1];
                        bit_stb <= 1'b1;
                        idx     <= idx + 4'd1;
                        count   <= idx + 4'd1;
                    end else if (wrap) begin
                        x_out   <= pat_q[PAT_W-1];
                        bit_stb <= 1'b1;
                        done    <= 1'b1;
                        idx     <= 4'd1;
                        count   <= 4'd1;
                    end else if (state_n == DONE) begin
                        // done is registered so it is high for the DONE cycle.
                        done <= 1'b1;
                    end
                end
                DONE:    x_out <= 1'b0;
                default: x_out <= 1'b0;
            endcase
            seg_q <= seg_decode(count);
        end
    end

endmodule

// File: tb/tb_seq_tx_gen.sv
module tb_seq_tx_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pat_in = 8'h00;
    logic [3:0] len_in = 4'd0;
    logic       load_valid = 1'b0;
    logic       start = 1'b0;
    logic       load_ready, x_out, bit_stb, busy, done, blinkled;
    logic       a, b, c, d, e, f, g;

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        logic        ld;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] exp_bits;
        int          exp_n;
    } vec_t;

    vec_t       vtab[6];
    logic [6:0] segtab[10];

    seq_tx_gen #(.PAT_W(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .pat_in(pat_in), .len_in(len_in),
        .load_valid(load_valid), .load_ready(load_ready), .start(start),
        .x_out(x_out), .bit_stb(bit_stb), .busy(busy), .done(done),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .blinkled(blinkled)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transmission; captures emitted bits and done pulses until busy drops.
    task automatic run_tx(input logic ld, input logic [7:0] p, input logic [3:0] l,
                          input bit disturb, output logic [15:0] bits,
                          output int n, output int nd);
        int  last_stb, done_gap, bad_gap;
        bit  fin;
        bits = '0; n = 0; nd = 0; last_stb = 0; done_gap = -1; bad_gap = 0; fin = 0;
        load_valid = ld; pat_in = p; len_in = l; start = 1'b1;
        step();
        load_valid = 1'b0; start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int cy = 1; cy < 200 && !fin; cy++) begin
            step();
            if (bit_stb) begin
                bits = {bits[14:0], x_out};
                n++;
                if (n > 1 && cy - last_stb != 4) bad_gap++;
                last_stb = cy;
                if (disturb && n == 1) begin
                    load_valid = 1'b1; pat_in = 8'h0F; len_in = 4'd8; start = 1'b1;
                end
                if (disturb && n == 2) begin
                    chk("load_ready_in_run", load_ready, 0);
                    load_valid = 1'b0; start = 1'b0;
                end
            end
            if (done) begin
                nd++;
                done_gap = cy - last_stb;
            end
            if (!busy) fin = 1;
        end
        chk("tx_timeout", fin, 1);
        chk("stb_spacing", bad_gap, 0);
        chk("done_gap", done_gap, 4);
        chk("x_out_idle", x_out, 0);
        chk("load_ready_idle", load_ready, 1);
    endtask

    initial begin
        logic [15:0] bits;
        int          n, nd, tog, waitc;
        logic        prev;

        segtab[0] = 7'b0000001; segtab[1] = 7'b1001111; segtab[2] = 7'b0010010;
        segtab[3] = 7'b0000110; segtab[4] = 7'b1001100; segtab[5] = 7'b0100100;
        segtab[6] = 7'b0100000; segtab[7] = 7'b0001111; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0000100;

        vtab[0] = '{1'b0, 8'h00,        4'd0,  16'h0003, 4};  // reset defaults: 0011
        vtab[1] = '{1'b1, 8'b1011_0110, 4'd8,  16'h00B6, 8};
        vtab[2] = '{1'b1, 8'hCA,        4'd0,  16'h00CA, 8};  // len 0 -> full width
        vtab[3] = '{1'b1, 8'h53,        4'd12, 16'h0053, 8};  // len > width -> full
        vtab[4] = '{1'b1, 8'hE0,        4'd3,  16'h0007, 3};
        vtab[5] = '{1'b1, 8'h81,        4'd1,  16'h0001, 1};

        // Reset state
        step(); step();
        chk("rst_x_out", x_out, 0);
        chk("rst_bit_stb", bit_stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_blinkled", blinkled, 0);
        chk("rst_segs", {a, b, c, d, e, f, g}, 7'b0000001);
        chk("rst_load_ready", load_ready, 1);
        rst = 1'b0;

        // Heartbeat: 16 cycles at TICK_DIV=4 give exactly 4 toggles
        tog = 0; prev = blinkled;
        for (int i = 0; i < 16; i++) begin
            step();
            if (blinkled != prev) tog++;
            prev = blinkled;
        end
        chk("blink_toggles", tog, 4);

        // Table-driven transmissions
        for (int v = 0; v < 6; v++) begin
            run_tx(vtab[v].ld, vtab[v].pat, vtab[v].len, 1'b0, bits, n, nd);
            chk($sformatf("v%0d_bits", v), bits, vtab[v].exp_bits);
            chk($sformatf("v%0d_count", v), n, vtab[v].exp_n);
            chk($sformatf("v%0d_dones", v), nd, 1);
            chk($sformatf("v%0d_segs", v), {a, b, c, d, e, f, g}, segtab[vtab[v].exp_n]);
        end

        // Load and restart attempts mid-RUN are ignored
        run_tx(1'b1, 8'hF0, 4'd4, 1'b1, bits, n, nd);
        chk("dist_bits", bits, 16'h000F);
        chk("dist_count", n, 4);
        chk("dist_dones", nd, 1);
        run_tx(1'b0, 8'h00, 4'd0, 1'b0, bits, n, nd);
        chk("dist_pat_kept", bits, 16'h000F);
        chk("dist_len_kept", n, 4);

        // Reset after the 2nd bit
        load_valid = 1'b1; pat_in = 8'hAA; len_in = 4'd8; start = 1'b1;
        step();
        load_valid = 1'b0; start = 1'b0;
        n = 0; waitc = 0;
        while (n < 2 && waitc < 100) begin
            step();
            if (bit_stb) n++;
            waitc++;
        end
        chk("rst_mid_wait", n, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_x_out", x_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_segs", {a, b, c, d, e, f, g}, 7'b0000001);
        run_tx(1'b0, 8'h00, 4'd0, 1'b0, bits, n, nd);
        chk("post_rst_bits", bits, 16'h0003);
        chk("post_rst_count", n, 4);

`ifdef SEQ_TX_LOOP_EN
        begin
            int  bad_blink, last_tog;
            bit  fin;
            bits = '0; n = 0; nd = 0; fin = 0; bad_blink = 0; last_tog = -1;
            prev = blinkled;
            start = 1'b1;
            for (int cy = 0; cy < 400 && !fin; cy++) begin
                step();
                if (blinkled != prev) begin
                    if (last_tog >= 0 && cy - last_tog != 4) bad_blink++;
                    last_tog = cy;
                end
                prev = blinkled;
                if (bit_stb) begin
                    bits = {bits[14:0], x_out};
                    n++;
                end
                if (done) nd++;
                if (nd == 2) start = 1'b0;
                if (cy > 0 && !busy) fin = 1;
            end
            start = 1'b0;
            chk("loop_finished", fin, 1);
            chk("loop_bits", bits, 16'h0333);
            chk("loop_count", n, 12);
            chk("loop_dones", nd, 3);
            chk("loop_blink", bad_blink, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
